// File: rtl/lasr_stim_pkg.sv
// lasr_stim_pkg: shared types, mode codes and LFSR helper for the latch stimulus sequencer
package lasr_stim_pkg;
  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_OPEN, S_CLOSE, S_CHECK, S_FIN} state_e;
  typedef struct packed {
    logic d;
    logic setb;
    logic rstb;
  } vec_t;
  localparam logic [1:0] MODE_WALK = 2'd0;
  localparam logic [1:0] MODE_LFSR = 2'd1;
  localparam logic [1:0] MODE_STRESS = 2'd2;
  localparam int LFSR_W = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/lasr_ref_model.sv
// lasr_ref_model: golden set/reset latch, reset dominant over set, both-low drives Q=QN=0
module lasr_ref_model (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic d,
  input  logic setb,
  input  logic rstb,
  output logic exp_q,
  output logic exp_qn
);
  logic q_q, q_d, qn_q, qn_d;
  // expected outputs follow the currently driven pins; held value used only when closed
  always_comb begin
    q_d = !rstb ? 1'b0 : !setb ? 1'b1 : en ? d : q_q;
    qn_d = !setb ? 1'b0 : !rstb ? 1'b1 : en ? ~d : qn_q;
  end
  assign exp_q = q_d;
  assign exp_qn = qn_d;
  // remember the latch state for the hold case
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= 1'b0;
      qn_q <= 1'b1;
    end else begin
      q_q <= q_d;
      qn_q <= qn_d;
    end
  end
endmodule

// File: rtl/lasr_stim_seq.sv
// lasr_stim_seq: phased stimulus sequencer and golden-compare checker for one set/reset latch cell
module lasr_stim_seq
  import lasr_stim_pkg::*;
#(
  parameter int NUM_VEC = 16,
  parameter int PHASE_CYC = 2,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 8'hA5,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic             START,
  input  logic [1:0]       MODE,
  output logic             DUT_D,
  output logic             DUT_CLK,
  output logic             DUT_SETB,
  output logic             DUT_RSTB,
  input  logic             DUT_Q,
  input  logic             DUT_QN,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] VEC_CNT,
  output logic [CNT_W-1:0] ERR_CNT
);
  localparam int PW = PHASE_CYC > 1 ? $clog2(PHASE_CYC) : 1;
  localparam int IW = NUM_VEC > 8 ? $clog2(NUM_VEC) : 3;

  state_e state_q, state_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [1:0] mode_q, mode_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_nxt;
  vec_t vec_q, vec_d;
  logic en_q, en_d, busy_q, busy_d, done_q, done_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d, ecnt_q, ecnt_d;
  logic exp_q, exp_qn, ph_last, idx_last, miss;

  function automatic vec_t gen(input logic [1:0] m, input logic [IW-1:0] i,
                               input logic [LFSR_W-1:0] l, input logic q);
    return m == MODE_LFSR ? {l[0], |l[2:1], |l[4:3]} :
           m == MODE_STRESS ? {~q, i[0], ~i[0]} : {i[0], ~i[1], ~i[2]};
  endfunction

  lasr_ref_model u_ref (
    .clk   (CLK),
    .rst_n (RSTB),
    .en    (en_q),
    .d     (vec_q.d),
    .setb  (vec_q.setb),
    .rstb  (vec_q.rstb),
    .exp_q (exp_q),
    .exp_qn(exp_qn)
  );

  // next-state: phase sequencing, vector generation at APPLY entry, compare at end of CHECK
  always_comb begin
    ph_last = ph_q == PW'(PHASE_CYC - 1);
    idx_last = idx_q == IW'(NUM_VEC - 1);
    lfsr_nxt = lfsr_step(lfsr_q);
    miss = (DUT_Q !== exp_q) || (DUT_QN !== exp_qn);
    state_d = state_q;
    ph_d = (state_q == S_IDLE || state_q == S_FIN || ph_last) ? '0 : ph_q + 1'b1;
    idx_d = idx_q;
    mode_d = mode_q;
    lfsr_d = lfsr_q;
    vec_d = vec_q;
    en_d = en_q;
    busy_d = busy_q;
    done_d = 1'b0;
    vcnt_d = vcnt_q;
    ecnt_d = ecnt_q;
    unique case (state_q)
      S_IDLE: if (START) begin
        state_d = S_APPLY;
        busy_d = 1'b1;
        mode_d = MODE;
        vcnt_d = '0;
        ecnt_d = '0;
        lfsr_d = LFSR_SEED;
        idx_d = '0;
        vec_d = gen(MODE, '0, LFSR_SEED, exp_q);
      end
      S_APPLY: if (ph_last) begin
        state_d = S_OPEN;
        en_d = 1'b1;
      end
      S_OPEN: if (ph_last) begin
        state_d = S_CLOSE;
        en_d = 1'b0;
      end
      S_CLOSE: if (ph_last) state_d = S_CHECK;
      S_CHECK: if (ph_last) begin
        vcnt_d = vcnt_q + 1'b1;
        ecnt_d = (miss && ecnt_q != '1) ? ecnt_q + 1'b1 : ecnt_q;
        if (idx_last) begin
          state_d = S_FIN;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          state_d = S_APPLY;
          idx_d = idx_q + 1'b1;
          lfsr_d = lfsr_nxt;
          vec_d = gen(mode_q, idx_d, lfsr_nxt, exp_q);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and registered outputs; reset aborts any run without a DONE
  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      state_q <= S_IDLE;
      ph_q <= '0;
      idx_q <= '0;
      mode_q <= MODE_WALK;
      lfsr_q <= LFSR_SEED;
      vec_q <= 3'b011;
      en_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      vcnt_q <= '0;
      ecnt_q <= '0;
    end else begin
      state_q <= state_d;
      ph_q <= ph_d;
      idx_q <= idx_d;
      mode_q <= mode_d;
      lfsr_q <= lfsr_d;
      vec_q <= vec_d;
      en_q <= en_d;
      busy_q <= busy_d;
      done_q <= done_d;
      vcnt_q <= vcnt_d;
      ecnt_q <= ecnt_d;
    end
  end

  assign DUT_D = vec_q.d;
  assign DUT_SETB = vec_q.setb;
  assign DUT_RSTB = vec_q.rstb;
  assign DUT_CLK = en_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign VEC_CNT = vcnt_q;
  assign ERR_CNT = ecnt_q;
endmodule

// File: tb/tb_lasr_stim_seq.sv
// tb_lasr_stim_seq: scoreboard bench driving an emulated latch cell with injectable faults
module tb_lasr_stim_seq;
  typedef struct {
    int vec;
    int err;
    int cyc;
  } exp_t;
  exp_t sbq[$];
  int n_cmp = 0;
  int n_bad = 0;
  int fault = 0;
  logic clk = 0;
  logic rstb = 0, start = 0, start6 = 0;
  logic [1:0] mode = 0, mode6 = 0;
  logic d, en, sb, rb, q, qn, busy, done, lq, lqn;
  logic d6, en6, sb6, rb6, busy6, done6, lq6, lqn6;
  logic [15:0] vc, ec;
  logic [3:0] vc6, ec6;

  always #5 clk = ~clk;

  lasr_stim_seq #(.NUM_VEC(8), .PHASE_CYC(2), .LFSR_SEED(8'hA5), .CNT_W(16)) dut (
    .CLK(clk), .RSTB(rstb), .START(start), .MODE(mode), .DUT_D(d), .DUT_CLK(en),
    .DUT_SETB(sb), .DUT_RSTB(rb), .DUT_Q(q), .DUT_QN(qn), .BUSY(busy), .DONE(done),
    .VEC_CNT(vc), .ERR_CNT(ec)
  );

  lasr_stim_seq #(.NUM_VEC(32), .PHASE_CYC(2), .LFSR_SEED(8'hA5), .CNT_W(4)) dut6 (
    .CLK(clk), .RSTB(rstb), .START(start6), .MODE(mode6), .DUT_D(d6), .DUT_CLK(en6),
    .DUT_SETB(sb6), .DUT_RSTB(rb6), .DUT_Q(~lq6), .DUT_QN(lqn6), .BUSY(busy6), .DONE(done6),
    .VEC_CNT(vc6), .ERR_CNT(ec6)
  );

  // emulated latch cells
  always_latch begin
    if (!rb) lq = 1'b0;
    else if (!sb) lq = 1'b1;
    else if (en) lq = d;
  end
  always_latch begin
    if (!sb) lqn = 1'b0;
    else if (!rb) lqn = 1'b1;
    else if (en) lqn = ~d;
  end
  always_latch begin
    if (!rb6) lq6 = 1'b0;
    else if (!sb6) lq6 = 1'b1;
    else if (en6) lq6 = d6;
  end
  always_latch begin
    if (!sb6) lqn6 = 1'b0;
    else if (!rb6) lqn6 = 1'b1;
    else if (en6) lqn6 = ~d6;
  end

  // fault 1: Q stuck 0, 2: QN stuck 1, 3: Q inverted
  assign q = fault == 1 ? 1'b0 : fault == 3 ? ~lq : lq;
  assign qn = fault == 2 ? 1'b1 : lqn;

  function automatic int exp_errs(input int m, input int nv, input int f);
    logic [7:0] l = 8'hA5;
    logic dd, s, r, eq, eqn;
    int e = 0;
    for (int k = 0; k < nv; k++) begin
      if (k > 0) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
      if (m == 1) begin
        dd = l[0]; s = |l[2:1]; r = |l[4:3];
      end else if (m == 2) begin
        dd = 1'b0; s = k[0]; r = ~k[0];
      end else begin
        dd = k[0]; s = ~k[1]; r = ~k[2];
      end
      eq = !r ? 1'b0 : !s ? 1'b1 : dd;
      eqn = !s ? 1'b0 : !r ? 1'b1 : ~dd;
      if ((f == 1 && eq) || (f == 2 && !eqn) || f == 3) e++;
    end
    return e;
  endfunction

  task automatic do_run(input int m, input int f, input int inject, input int abort_at, input string tag);
    exp_t e;
    int cyc = 0;
    fault = f;
    e.vec = 8;
    e.err = exp_errs(m, 8, f);
    e.cyc = 64;
    if (abort_at < 0) sbq.push_back(e);
    mode = 2'(m);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    mode = 2'(m + 1);
    for (int n = 1; n <= 200 && cyc == 0; n++) begin
      start = (n == inject);
      rstb = (n != abort_at);
      @(posedge clk); #1;
      if (n == abort_at) begin
        n_cmp++;
        if ({busy, done, sb, rb, en, d} !== 6'b001100 || vc !== 0 || ec !== 0) begin
          n_bad++;
          $display("FAIL %s abort_state: busy,done,setb,rstb,clk,d=%b vc=%0d ec=%0d required 001100 vc=0 ec=0",
                   tag, {busy, done, sb, rb, en, d}, vc, ec);
        end
      end
      if (n == 12 && abort_at < 0) begin
        n_cmp++;
        if (busy !== 1'b1) begin
          n_bad++;
          $display("FAIL %s busy_mid_run: got %b required 1", tag, busy);
        end
      end
      if (done === 1'b1) cyc = n;
    end
    start = 0;
    rstb = 1;
    if (abort_at >= 0) begin
      n_cmp++;
      if (cyc != 0) begin
        n_bad++;
        $display("FAIL %s no_done_after_abort: DONE at cycle %0d required none", tag, cyc);
      end
    end else begin
      e = sbq.pop_front();
      n_cmp++;
      if (cyc != e.cyc) begin
        n_bad++;
        $display("FAIL %s done_cycle: got %0d required %0d", tag, cyc, e.cyc);
      end
      n_cmp++;
      if (vc !== 16'(e.vec)) begin
        n_bad++;
        $display("FAIL %s vec_cnt: got %0d required %0d", tag, vc, e.vec);
      end
      n_cmp++;
      if (ec !== 16'(e.err)) begin
        n_bad++;
        $display("FAIL %s err_cnt: got %0d required %0d", tag, ec, e.err);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL %s done_pulse: done=%b busy=%b required 0 0", tag, done, busy);
      end
    end
  endtask

  task automatic test_reset;
    rstb = 0;
    repeat (2) @(posedge clk);
    #1 rstb = 1;
    repeat (3) @(posedge clk);
    #1 rstb = 0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({sb, rb, en, d} !== 4'b1100) begin
      n_bad++;
      $display("FAIL reset_pins: setb,rstb,clk,d=%b required 1100", {sb, rb, en, d});
    end
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_status: busy,done=%b required 00", {busy, done});
    end
    n_cmp++;
    if (ec !== 0 || vc !== 0) begin
      n_bad++;
      $display("FAIL reset_counts: vc=%0d ec=%0d required 0 0", vc, ec);
    end
    n_cmp++;
    if (ec6 !== 0 || busy6 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_dut6: ec=%0d busy=%b required 0 0", ec6, busy6);
    end
    rstb = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_walk;
    do_run(0, 0, -1, -1, "walk_ideal");
    do_run(3, 0, -1, -1, "mode3_ideal");
  endtask

  task automatic test_stuck;
    do_run(0, 1, -1, -1, "walk_q_stuck0");
    do_run(0, 2, -1, -1, "walk_qn_stuck1");
    do_run(3, 1, -1, -1, "mode3_q_stuck0");
  endtask

  task automatic test_lfsr;
    do_run(1, 0, -1, -1, "lfsr_ideal");
    do_run(1, 1, -1, -1, "lfsr_q_stuck0");
    do_run(1, 2, -1, -1, "lfsr_qn_stuck1");
  endtask

  task automatic test_stress;
    do_run(2, 0, -1, -1, "stress_ideal");
    do_run(2, 3, -1, -1, "stress_q_inv");
  endtask

  task automatic test_start_ignored;
    do_run(0, 1, 19, -1, "start_while_busy");
  endtask

  task automatic test_abort;
    do_run(0, 1, -1, 26, "abort_vec3");
    do_run(0, 1, -1, -1, "after_abort");
  endtask

  task automatic test_back_to_back;
    do_run(1, 1, -1, -1, "b2b_first");
    do_run(0, 2, -1, -1, "b2b_second");
  endtask

  task automatic test_saturate;
    exp_t e;
    int cyc = 0;
    int ne;
    ne = exp_errs(2, 32, 3);
    e.vec = 32 % 16;
    e.err = ne > 15 ? 15 : ne;
    e.cyc = 256;
    sbq.push_back(e);
    mode6 = 2;
    start6 = 1;
    @(posedge clk); #1;
    start6 = 0;
    mode6 = 0;
    for (int n = 1; n <= 400 && cyc == 0; n++) begin
      @(posedge clk); #1;
      if (done6 === 1'b1) cyc = n;
    end
    e = sbq.pop_front();
    n_cmp++;
    if (cyc != e.cyc) begin
      n_bad++;
      $display("FAIL sat_done_cycle: got %0d required %0d", cyc, e.cyc);
    end
    n_cmp++;
    if (vc6 !== 4'(e.vec)) begin
      n_bad++;
      $display("FAIL sat_vec_cnt: got %0d required %0d", vc6, e.vec);
    end
    n_cmp++;
    if (ec6 !== 4'(e.err)) begin
      n_bad++;
      $display("FAIL sat_err_cnt: got %0d required %0d", ec6, e.err);
    end
  endtask

  initial begin
    test_reset;
    test_walk;
    test_stuck;
    test_lfsr;
    test_stress;
    test_start_ignored;
    test_abort;
    test_back_to_back;
    test_saturate;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
